counter4_arbiter: RTL and testbench

Round-robin controller that shares one 4-bit mode counter between two requesters. Each requester asks for a "load start value, then count up or down until target value" operation. The block arbitrates between them, drives the counter's Mode/Din inputs, watches its Out value, and signals completion back to the granted requester. It sits directly between the requesters and the Counter4 instance.

---
 rtl/counter4_arbiter.sv | 152 +++++++++++++++
 tb/tb_counter4_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter4_arbiter.sv
// counter4_arbiter
//   Round-robin controller that shares one 4-bit mode counter between two
//   requesters. A granted requester gets "load start, then count up/down until
//   target". The block drives the counter's Mode/Din and watches its Out.
//
//   Optional feature: define CTRL_TIMEOUT_EN to bound the RUN state to
//   TIMEOUT cycles. On expiry the operation ends with done and err together.
//
//   Ports
//     Ck                  clock, rising edge
//     Reset               synchronous, active-low
//     req0/req1           operation request
//     dir0/dir1           1 = count up, 0 = count down
//     start0/start1       value loaded into the counter
//     target0/target1     value at which counting stops
//     gnt0/gnt1           requester owns the counter
//     done0/done1         one-cycle completion pulse
//     err                 one-cycle abort pulse (timeout only)
//     Mode                counter mode: 00 hold, 01 up, 10 down, 11 load
//     Din                 counter load data
//     CntOut              counter Out (registered in the counter)
module counter4_arbiter #(
    parameter bit RR_INIT = 1'b0,
    parameter int TIMEOUT = 17
) (
    input  logic       Ck,
    input  logic       Reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       dir0,
    input  logic       dir1,
    input  logic [3:0] start0,
    input  logic [3:0] start1,
    input  logic [3:0] target0,
    input  logic [3:0] target1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [1:0] Mode,
    output logic [3:0] Din,
    input  logic [3:0] CntOut
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t     state;
    logic       own;       // granted requester
    logic       prio;      // requester that wins a tie
    logic       dir_q;
    logic [3:0] start_q;
    logic [3:0] target_q;
    logic       pick;
    logic       match;

    // Single requester wins outright; a tie goes to the priority pointer.
    assign pick  = (req0 & req1) ? prio : req1;
    assign match = (CntOut == target_q);

`ifdef CTRL_TIMEOUT_EN
    localparam int RW = $clog2(TIMEOUT + 1);
    logic [RW-1:0] run_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge Ck) begin
        if (!Reset) begin
            state    <= S_IDLE;
            own      <= 1'b0;
            prio     <= RR_INIT;
            dir_q    <= 1'b0;
            start_q  <= 4'd0;
            target_q <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            err      <= 1'b0;
            run_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        own      <= pick;
                        dir_q    <= pick ? dir1    : dir0;
                        start_q  <= pick ? start1  : start0;
                        target_q <= pick ? target1 : target0;
                        gnt0     <= ~pick;
                        gnt1     <= pick;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_RUN;
`ifdef CTRL_TIMEOUT_EN
                    run_cnt <= '0;
`endif
                end
                S_RUN: begin
                    if (match) begin
                        done0 <= ~own;
                        done1 <= own;
                        state <= S_DONE;
`ifdef CTRL_TIMEOUT_EN
                    end else if (run_cnt == RW'(TIMEOUT - 1)) begin
                        // this is the TIMEOUT-th RUN cycle without a match
                        done0 <= ~own;
                        done1 <= own;
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
`endif
                    end
                end
                default: begin // S_DONE
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                    prio  <= ~own;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Mode must react to CntOut within the same RUN cycle so the counter
    // stops exactly on target; hence it is decoded combinationally.
    always_comb begin
        Mode = 2'b00;
        Din  = 4'd0;
        case (state)
            S_LOAD: begin
                Mode = 2'b11;
                Din  = start_q;
            end
            S_RUN: begin
                if (!match) Mode = dir_q ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_counter4_arbiter.sv
module tb_counter4_arbiter;

    localparam bit RR_INIT = 1'b0;
    localparam int TIMEOUT = 17;

    logic       Ck = 1'b0;
    logic       Reset = 1'b0;
    logic       req0 = 0, req1 = 0, dir0 = 0, dir1 = 0;
    logic [3:0] start0 = 0, start1 = 0, target0 = 0, target1 = 0;
    logic       gnt0, gnt1, done0, done1, err;
    logic [1:0] Mode;
    logic [3:0] Din;
    logic [3:0] CntOut = 4'd0;
    logic       frozen = 1'b0;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    counter4_arbiter #(.RR_INIT(RR_INIT), .TIMEOUT(TIMEOUT)) dut (
        .Ck(Ck), .Reset(Reset),
        .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
        .start0(start0), .start1(start1), .target0(target0), .target1(target1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .Mode(Mode), .Din(Din), .CntOut(CntOut)
    );

    always #5 Ck = ~Ck;

    // Counter4 stand-in; 'frozen' pins it at 0 to provoke a timeout.
    always @(posedge Ck) begin
        if (frozen) CntOut <= 4'd0;
        else case (Mode)
            2'b01: CntOut <= CntOut + 4'd1;
            2'b10: CntOut <= CntOut - 4'd1;
            2'b11: CntOut <= Din;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: timeline of one operation measured in cycles after
    // the grant edge. ph=0 idle; ph=1 load; ph=2..rl+1 run; ph=rl+2 done.
    int         ph = 0;
    int         rl = 0;
    bit         m_own, m_dir, m_to, m_nxt = RR_INIT;
    logic [3:0] m_start, m_target, m_k;

    always @(posedge Ck) begin
        if (!Reset) begin
            ph = 0;
            m_nxt = RR_INIT;
        end else if (ph == 0) begin
            if (req0 | req1) begin
                m_own    = (req0 & req1) ? m_nxt : req1;
                m_dir    = m_own ? dir1 : dir0;
                m_start  = m_own ? start1 : start0;
                m_target = m_own ? target1 : target0;
                m_k      = m_dir ? m_target - m_start : m_start - m_target;
`ifdef CTRL_TIMEOUT_EN
                m_to = frozen;
                rl   = frozen ? TIMEOUT : int'(m_k) + 1;
`else
                m_to = 0;
                rl   = frozen ? 100000 : int'(m_k) + 1;
`endif
                ph = 1;
            end
        end else if (ph == rl + 2) begin
            ph = 0;
            m_nxt = ~m_own;
        end else begin
            ph++;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge Ck) begin
        logic       e_g, e_d, e_e;
        logic [1:0] e_m;
        logic [3:0] e_din;
        if (chk_on) begin
            e_g = 0; e_d = 0; e_e = 0; e_m = 2'b00; e_din = 4'd0;
            if (ph != 0) begin
                e_g = 1;
                if (ph == 1) begin
                    e_m = 2'b11; e_din = m_start;
                end else if (ph <= rl + 1) begin
                    e_m = (ph == rl + 1 && !m_to) ? 2'b00 : (m_dir ? 2'b01 : 2'b10);
                end else begin
                    e_d = 1; e_e = m_to;
                    if (!m_to) chk("cnt_at_done", CntOut, m_target);
                end
            end
            chk("gnt", {gnt1, gnt0}, {e_g & m_own, e_g & ~m_own});
            chk("done", {done1, done0}, {e_d & m_own, e_d & ~m_own});
            chk("err", err, e_e);
            chk("mode_din", {Mode, Din}, {e_m, e_din});
        end
    end

    task automatic op(input bit who, input bit d, input logic [3:0] s, input logic [3:0] t);
        if (who) begin req1 = 1; dir1 = d; start1 = s; target1 = t; end
        else     begin req0 = 1; dir0 = d; start0 = s; target0 = t; end
        @(negedge Ck);            // cycle 1 after grant edge
        req0 = 0; req1 = 0;
    endtask

    initial begin
        int seq[5];
        int order[3];
        int ng;
        bit pg0, pg1;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp2 [5];
        int order [3];
        int ng;
        exp2[0] = 2; exp2[1] = 1; exp2[2] = 0; exp2[3] = 15; exp2[4] = 14;

        Reset = 0;
        @(negedge Ck); @(negedge Ck);
        chk_on = 1;
        chk("reset_state", {gnt0, gnt1, done0, done1, err, Mode, Din}, 0);
        Reset = 1;
        @(negedge Ck);

        // 1: up count 3 -> 7
        op(0, 1, 4'd3, 4'd7);
        chk("t1_load", {Mode, Din}, {2'b11, 4'd3});
        repeat (6) @(negedge Ck);
        chk("t1_done", {gnt0, done0, CntOut}, {1'b1, 1'b1, 4'd7});
        @(negedge Ck);

        // 2: down count with wrap 2 -> 14
        op(1, 0, 4'd2, 4'd14);
        for (int i = 0; i < 5; i++) begin
            @(negedge Ck);
            chk("t2_seq", CntOut, exp2[i]);
        end
        @(negedge Ck);
        chk("t2_done", {gnt1, done1}, 2'b11);
        @(negedge Ck);

        // 3: zero steps
        op(0, 0, 4'd9, 4'd9);
        @(negedge Ck);
        chk("t3_hold", Mode, 2'b00);
        @(negedge Ck);
        chk("t3_done", done0, 1'b1);
        @(negedge Ck);

        // 4: simultaneous requests from reset
        Reset = 0;
        req0 = 1; dir0 = 1; start0 = 4'd1; target0 = 4'd2;
        req1 = 1; dir1 = 0; start1 = 4'd5; target1 = 4'd3;
        @(negedge Ck);
        Reset = 1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            logic pg0, pg1;
            pg0 = gnt0; pg1 = gnt1;
            @(negedge Ck);
            if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
                order[ng] = gnt1 ? 1 : 0;
                ng++;
                if (ng == 3) begin req0 = 0; req1 = 0; end
            end
            chk("t4_excl", gnt0 & gnt1, 1'b0);
        end
        chk("t4_count", ng, 3);
        if (ng == 3) chk("t4_order", {order[0][0], order[1][0], order[2][0]}, 3'b010);
        req0 = 0; req1 = 0;
        repeat (8) @(negedge Ck);

        // 5: reset mid-run, then a fresh operation
        op(0, 1, 4'd0, 4'd15);
        repeat (3) @(negedge Ck);
        Reset = 0;
        @(negedge Ck);
        chk("t5_abort", {gnt0, done0, Mode}, 0);
        Reset = 1;
        @(negedge Ck);
        op(0, 1, 4'd4, 4'd6);
        chk("t5_reload", {gnt0, Mode, Din}, {1'b1, 2'b11, 4'd4});
        repeat (6) @(negedge Ck);

        // 6: counter stuck at 0, target never reached
        frozen = 1;
        op(0, 1, 4'd3, 4'd5);
`ifdef CTRL_TIMEOUT_EN
        repeat (TIMEOUT + 1) @(negedge Ck);
        chk("t6_timeout", {done0, err, Mode}, {1'b1, 1'b1, 2'b00});
        @(negedge Ck);
`else
        repeat (29) @(negedge Ck);
        chk("t6_stuck", {gnt0, done0, err, Mode}, {1'b1, 1'b0, 1'b0, 2'b01});
        Reset = 0;
        @(negedge Ck);
        Reset = 1;
`endif
        frozen = 0;
        @(negedge Ck);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            req0    = $urandom_range(0, 1);
            req1    = $urandom_range(0, 1);
            dir0    = $urandom_range(0, 1);
            dir1    = $urandom_range(0, 1);
            start0  = 4'($urandom);
            start1  = 4'($urandom);
            target0 = 4'($urandom);
            target1 = 4'($urandom);
            Reset   = ($urandom_range(0, 79) != 0);
            @(negedge Ck);
        end
        Reset = 1; req0 = 0; req1 = 0;
        repeat (20) @(negedge Ck);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
